fb_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM (128x128 x 6-bit palette indices) between
//  the VGA scanout reader and pixel writers (drawing/loader logic). Scanout has

---
 rtl/fb_arbiter_if.sv | 44 ++++
 rtl/fb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// fb_arbiter_if : request, response and RAM-side bundle of the framebuffer arbiter
// Rev 1.0
// ============================================================================
interface fb_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 6
);
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_rdata;
  logic          scan_rvalid;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output scan_req, scan_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    input  scan_rdata, scan_rvalid, wr_ready, clr_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  scan_req, scan_addr, wr_valid, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    output scan_rdata, scan_rvalid, wr_ready, clr_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// fb_arbiter : single-port framebuffer sharing (scanout > clear > write FIFO)
// Rev 1.0
// ============================================================================
module fb_arbiter #(
  parameter int AW         = 14,
  parameter int DW         = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  fb_arbiter_if.slave bus
);
  localparam int              c_PW       = $clog2(FIFO_DEPTH);
  localparam logic [c_PW:0]   c_FULL     = (c_PW+1)'(FIFO_DEPTH);
  localparam logic [c_PW:0]   c_CNT_ONE  = (c_PW+1)'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
  localparam logic [AW-1:0]   c_ADDR_ONE = AW'(1);
  localparam logic [AW-1:0]   c_ADDR_END = {AW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [AW+DW-1:0] r_fifo [FIFO_DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_PW:0]    r_count;
  logic [AW-1:0]    r_clr_addr;
  logic [DW-1:0]    r_clr_color;
  logic             r_scan_rvalid;

  logic          w_empty;
  logic          w_full;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_scan_gnt;
  logic          w_clr_gnt;
  logic          w_fifo_gnt;
  logic          w_en;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign {w_head_addr, w_head_data} = r_fifo[r_rd_ptr];

  // Internal handshake is left ungated by rst; flops are held by the async
  // reset anyway, and only the external view is forced quiet during reset.
  assign w_ready = ~w_full & (r_state == S_IDLE);
  assign w_push  = bus.wr_valid & w_ready;
  assign w_pop   = w_fifo_gnt;

  // Grant, RAM mux and next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_scan_gnt  = 1'b0;
    w_clr_gnt   = 1'b0;
    w_fifo_gnt  = 1'b0;
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_addr      = w_head_addr;
    w_wdata     = w_head_data;

    if (bus.scan_req) begin
      w_scan_gnt = 1'b1;
      w_en       = 1'b1;
      w_addr     = bus.scan_addr;
    end else if (r_state == S_CLEAR) begin
      w_clr_gnt = 1'b1;
      w_en      = 1'b1;
      w_we      = 1'b1;
      w_addr    = r_clr_addr;
      w_wdata   = r_clr_color;
    end else if (!w_empty) begin
      w_fifo_gnt = 1'b1;
      w_en       = 1'b1;
      w_we       = 1'b1;
    end

    case (r_state)
      S_IDLE:  if (bus.clr_start) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_gnt && (r_clr_addr == c_ADDR_END)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {bus.wr_addr, bus.wr_data};
  end

  // The clear address restarts on every DRAIN cycle so an aborted clear
  // never leaks its position into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.clr_start) r_clr_color <= bus.clr_color;
      if (w_clr_gnt) begin
        r_clr_addr <= r_clr_addr + c_ADDR_ONE;
      end else if (r_state == S_DRAIN) begin
        r_clr_addr <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_rvalid <= 1'b0;
    end else begin
      r_scan_rvalid <= w_scan_gnt;
    end
  end

  assign bus.scan_rdata  = bus.mem_rdata;
  assign bus.scan_rvalid = r_scan_rvalid;
  assign bus.wr_ready    = w_ready & ~rst;
  assign bus.clr_busy    = (r_state != S_IDLE);
  assign bus.mem_en      = w_en & ~rst;
  assign bus.mem_we      = w_we & ~rst;
  assign bus.mem_addr    = w_addr;
  assign bus.mem_wdata   = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fb_arbiter : directed + random checks of fb_arbiter against a queue model
// Rev 1.0
// ============================================================================
module tb_fb_arbiter;
  localparam int AW = 14;
  localparam int DW = 6;
  localparam int NW = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fb_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Environment RAM: registered read, preloaded with addr[5:0] on the first edge.
  logic [DW-1:0] ram [NW];
  bit            loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < NW; i++) ram[i] <= DW'(i);
      loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Reference model state.
  wr_t           wq[$];
  logic [DW-1:0] shadow [NW];
  bit            busy_m;
  bit            drained_m;
  int            clr_next;
  logic [DW-1:0] clr_col;
  bit            prev_scan;
  logic [DW-1:0] prev_exp;
  int            busy_cycles;
  bit            last_acc;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check at negedge, advance the model to the state after the edge.
  task automatic cycle();
    bit            scan, rdy, wr_due, clr_due, busy0, empty0;
    wr_t           e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    last_acc = 1'b0;
    @(negedge clk);
    if (rst) begin
      chk("rst_mem_en",   bus.mem_en,      0);
      chk("rst_mem_we",   bus.mem_we,      0);
      chk("rst_wr_ready", bus.wr_ready,    0);
      chk("rst_clr_busy", bus.clr_busy,    0);
      chk("rst_rvalid",   bus.scan_rvalid, 0);
      wq.delete();
      busy_m    = 1'b0;
      drained_m = 1'b0;
      prev_scan = 1'b0;
    end else begin
      scan   = bus.scan_req;
      busy0  = busy_m;
      empty0 = (wq.size() == 0);
      rdy    = !busy_m && (wq.size() < 4);
      if (bus.clr_busy) busy_cycles++;
      chk("scan_rvalid", bus.scan_rvalid, prev_scan);
      if (prev_scan) chk("scan_rdata", bus.scan_rdata, prev_exp);
      chk("clr_busy", bus.clr_busy, busy_m);
      chk("wr_ready", bus.wr_ready, rdy);
      wr_due  = !scan && !empty0;
      clr_due = !scan && empty0 && busy_m && drained_m;
      chk("mem_en", bus.mem_en, scan || wr_due || clr_due);
      chk("mem_we", bus.mem_we, wr_due || clr_due);
      ea = '0;
      ed = '0;
      if (scan) begin
        chk("scan_addr", bus.mem_addr, bus.scan_addr);
        prev_exp = shadow[bus.scan_addr];
      end
      if (wr_due) begin
        e  = wq.pop_front();
        ea = e.a;
        ed = e.d;
      end
      if (clr_due) begin
        ea = AW'(clr_next);
        ed = clr_col;
        clr_next++;
      end
      if (wr_due || clr_due) begin
        chk("wr_addr", bus.mem_addr, ea);
        chk("wr_data", bus.mem_wdata, ed);
        shadow[ea] = ed;
      end
      prev_scan = scan;
      if (bus.wr_valid && rdy) begin
        e.a = bus.wr_addr;
        e.d = bus.wr_data;
        wq.push_back(e);
        last_acc = 1'b1;
      end
      if (busy0 && empty0) drained_m = 1'b1;
      if (clr_due && clr_next == NW) begin
        busy_m    = 1'b0;
        drained_m = 1'b0;
      end
      if (bus.clr_start && !busy0) begin
        busy_m    = 1'b1;
        drained_m = 1'b0;
        clr_col   = bus.clr_color;
        clr_next  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] t2_addr [8];
    int n, c;
    total = 0;
    bad   = 0;
    for (int i = 0; i < NW; i++) shadow[i] = DW'(i);
    bus.scan_req = 0; bus.scan_addr = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_start = 0; bus.clr_color = '0;

    // Reset state.
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Continuous scanout over the preloaded k->k region.
    for (int k = 0; k < 16; k++) begin
      bus.scan_req  = 1'b1;
      bus.scan_addr = AW'(k);
      cycle();
    end
    bus.scan_req = 1'b0;
    cycle();

    // Write burst with scan on phase 3 of every 4 cycles.
    n = 0;
    c = 0;
    while (n < 8 && c < 200) begin
      bus.scan_req  = (c % 4 == 3);
      bus.scan_addr = AW'($urandom_range(0, 63));
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = AW'(1000 + n);
      bus.wr_data   = DW'($urandom);
      t2_addr[n]    = bus.wr_addr;
      cycle();
      if (last_acc) n++;
      c++;
    end
    chk("burst_accepted", n, 8);
    bus.wr_valid = 1'b0;
    bus.scan_req = 1'b0;
    repeat (10) cycle();
    for (int k = 0; k < 8; k++) begin
      bus.scan_req  = 1'b1;
      bus.scan_addr = t2_addr[k];
      cycle();
    end
    bus.scan_req = 1'b0;
    cycle();

    // Scan held for 20 cycles while the FIFO fills.
    n = 0;
    for (int k = 0; k < 20; k++) begin
      bus.scan_req  = 1'b1;
      bus.scan_addr = AW'($urandom_range(0, 63));
      bus.wr_valid  = (n < 4);
      bus.wr_addr   = AW'(2000 + n);
      bus.wr_data   = DW'($urandom);
      cycle();
      if (last_acc) n++;
    end
    chk("full_accepted", n, 4);
    bus.wr_valid = 1'b0;
    bus.scan_req = 1'b0;
    repeat (6) cycle();

    // Randomized mix of scans and writes on a small address window.
    for (int k = 0; k < 2000; k++) begin
      bus.scan_req  = ($urandom_range(0, 1) == 1);
      bus.scan_addr = AW'($urandom_range(0, 63));
      bus.wr_valid  = ($urandom_range(0, 2) != 0);
      bus.wr_addr   = AW'($urandom_range(0, 63));
      bus.wr_data   = DW'($urandom);
      cycle();
    end
    bus.scan_req = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (8) cycle();

    // Full clear to 0x2A with no scans; a second clr_start mid-way is ignored.
    busy_cycles   = 0;
    bus.clr_start = 1'b1;
    bus.clr_color = 6'h2A;
    cycle();
    bus.clr_start = 1'b0;
    n = 0;
    while (busy_m && n < 17000) begin
      bus.clr_start = (n == 3000);
      bus.clr_color = 6'h15;
      bus.wr_valid  = ($urandom_range(0, 3) == 0);
      bus.wr_addr   = AW'($urandom);
      bus.wr_data   = DW'($urandom);
      cycle();
      n++;
    end
    bus.clr_start = 1'b0;
    bus.wr_valid  = 1'b0;
    cycle();
    chk("clr_done", bus.clr_busy, 0);
    chk("clr_busy_len", busy_cycles, NW + 1);
    for (int a = 0; a < NW; a++) begin
      bus.scan_req  = 1'b1;
      bus.scan_addr = AW'(a);
      cycle();
    end
    bus.scan_req = 1'b0;
    cycle();

    // Two pending writes, then a black clear.
    n = 0;
    c = 0;
    while (n < 2 && c < 20) begin
      bus.scan_req  = 1'b1;
      bus.scan_addr = AW'(7);
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = AW'(100 + n);
      bus.wr_data   = DW'(6'h3F - n);
      cycle();
      if (last_acc) n++;
      c++;
    end
    bus.wr_valid  = 1'b0;
    bus.scan_req  = 1'b0;
    bus.clr_start = 1'b1;
    bus.clr_color = 6'h00;
    cycle();
    bus.clr_start = 1'b0;
    n = 0;
    while (busy_m && n < 17000) begin
      bus.wr_valid = ($urandom_range(0, 1) == 1);
      bus.wr_addr  = AW'($urandom);
      cycle();
      n++;
    end
    bus.wr_valid = 1'b0;
    cycle();
    chk("clr2_done", bus.clr_busy, 0);
    for (int k = 0; k < 2; k++) begin
      bus.scan_req  = 1'b1;
      bus.scan_addr = AW'(100 + k);
      cycle();
    end
    bus.scan_req = 1'b0;
    cycle();

    // Reset in the middle of a clear.
    bus.clr_start = 1'b1;
    bus.clr_color = 6'h11;
    cycle();
    bus.clr_start = 1'b0;
    n = 0;
    while (clr_next < 5000 && n < 6000) begin
      cycle();
      n++;
    end
    chk("clr_reached_5000", clr_next, 5000);
    rst          = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(300);
    bus.wr_data  = DW'(9);
    repeat (3) cycle();
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    cycle();
    chk("post_rst_ready", bus.wr_ready, 1);
    chk("post_rst_busy",  bus.clr_busy, 0);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
